// File: rtl/video_out_fetch.sv
// Wishbone read master that fetches one frame of packed 8-bit pixels into the video-out FIFO.
// Define VIDEO_OUT_FETCH_AUTORELOAD_EN to refetch the same base continuously when no new address is pending.
module video_out_fetch #(
  parameter int unsigned P_WIDTH    = 640,
  parameter int unsigned P_HEIGHT   = 480,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned IRQ_CYCLES = 3
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        reg_ctr,
  input  logic [31:0] reg_data,
  input  logic        fifo_room,
  output logic [31:0] fifo_data,
  output logic        fifo_we,
  output logic        interrupt,
  output logic        bus_err,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_WE_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic [31:0] p_wb_ADR_O,
  input  logic [31:0] p_wb_DAT_I,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I
);

  localparam int unsigned FRAME_WORDS = P_WIDTH * P_HEIGHT / 4;
  localparam int unsigned WC_W        = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BC_W        = $clog2(BURST_LEN + 1);
  localparam int unsigned IC_W        = $clog2(IRQ_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ROOM,
    S_BUS,
    S_ERR_GAP,
    S_DONE
  } state_t;

  state_t          state;
  logic            reg_ctr_d;
  logic [31:0]     base;
  logic [31:0]     pending;
  logic            pending_vld;
  logic [WC_W-1:0] word_cnt;
  logic [BC_W-1:0] burst_cnt;
  logic [IC_W-1:0] irq_cnt;

  logic            new_addr_c;
  logic [31:0]     addr_in_c;
  logic            last_beat_c;
  logic            last_word_c;

  // Read-only master: write enable and byte selects are fixed.
  assign p_wb_WE_O  = 1'b0;
  assign p_wb_SEL_O = 4'hF;

  assign new_addr_c  = reg_ctr & ~reg_ctr_d;
  assign addr_in_c   = reg_data & 32'hFFFF_FFFC;
  assign last_beat_c = (burst_cnt == BC_W'(BURST_LEN - 1));
  assign last_word_c = (word_cnt == WC_W'(FRAME_WORDS - 1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= S_IDLE;
      reg_ctr_d   <= 1'b0;
      base        <= '0;
      pending     <= '0;
      pending_vld <= 1'b0;
      word_cnt    <= '0;
      burst_cnt   <= '0;
      irq_cnt     <= '0;
      fifo_data   <= '0;
      fifo_we     <= 1'b0;
      interrupt   <= 1'b0;
      bus_err     <= 1'b0;
      p_wb_CYC_O  <= 1'b0;
      p_wb_STB_O  <= 1'b0;
      p_wb_ADR_O  <= '0;
    end else begin
      reg_ctr_d <= reg_ctr;
      fifo_we   <= 1'b0;

      // Addresses arriving while busy wait here; the newest one wins.
      if (new_addr_c && (state != S_IDLE)) begin
        pending     <= addr_in_c;
        pending_vld <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (new_addr_c) begin
            base    <= addr_in_c;
            bus_err <= 1'b0;
            state   <= S_WAIT_ROOM;
          end
        end

        S_WAIT_ROOM: begin
          if (fifo_room) begin
            p_wb_CYC_O <= 1'b1;
            p_wb_STB_O <= 1'b1;
            p_wb_ADR_O <= base + (32'(word_cnt) << 2);
            state      <= S_BUS;
          end
        end

        S_BUS: begin
          // ERR dominates ACK; the beat is retried after a one-cycle strobe gap.
          if (p_wb_ERR_I) begin
            bus_err    <= 1'b1;
            p_wb_STB_O <= 1'b0;
            state      <= S_ERR_GAP;
          end else if (p_wb_ACK_I) begin
            fifo_data <= p_wb_DAT_I;
            fifo_we   <= 1'b1;
            if (last_beat_c) begin
              p_wb_CYC_O <= 1'b0;
              p_wb_STB_O <= 1'b0;
              burst_cnt  <= '0;
              if (last_word_c) begin
                word_cnt  <= '0;
                interrupt <= 1'b1;
                irq_cnt   <= IC_W'(IRQ_CYCLES - 1);
                state     <= S_DONE;
              end else begin
                word_cnt <= word_cnt + WC_W'(1);
                state    <= S_WAIT_ROOM;
              end
            end else begin
              word_cnt   <= word_cnt + WC_W'(1);
              burst_cnt  <= burst_cnt + BC_W'(1);
              p_wb_ADR_O <= p_wb_ADR_O + 32'd4;
            end
          end
        end

        S_ERR_GAP: begin
          p_wb_STB_O <= 1'b1;
          state      <= S_BUS;
        end

        S_DONE: begin
          if (irq_cnt != '0) begin
            irq_cnt <= irq_cnt - IC_W'(1);
          end else begin
            interrupt <= 1'b0;
            // An edge landing on the exit cycle is taken directly.
            if (new_addr_c) begin
              base        <= addr_in_c;
              pending_vld <= 1'b0;
              bus_err     <= 1'b0;
              state       <= S_WAIT_ROOM;
            end else if (pending_vld) begin
              base        <= pending;
              pending_vld <= 1'b0;
              bus_err     <= 1'b0;
              state       <= S_WAIT_ROOM;
            end else begin
`ifdef VIDEO_OUT_FETCH_AUTORELOAD_EN
              bus_err <= 1'b0;
              state   <= S_WAIT_ROOM;
`else
              state   <= S_IDLE;
`endif
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_out_fetch.sv
// Directed bench for video_out_fetch: 8-word frames in 4-word bursts against a
// zero-wait slave that returns the address as data.
module tb_video_out_fetch;

  logic        clk = 1'b0;
  logic        nRST;
  logic        reg_ctr;
  logic [31:0] reg_data;
  logic        fifo_room;
  logic [31:0] fifo_data;
  logic        fifo_we;
  logic        interrupt;
  logic        bus_err;
  logic        p_wb_CYC_O;
  logic        p_wb_STB_O;
  logic        p_wb_WE_O;
  logic [3:0]  p_wb_SEL_O;
  logic [31:0] p_wb_ADR_O;
  logic [31:0] p_wb_DAT_I;
  logic        p_wb_ACK_I;
  logic        p_wb_ERR_I;

  int          tests = 0;
  int          fails = 0;
  int          err_req = 0;
  int          err_ack = 0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] wr_q[$];
  logic [31:0] adr_q[$];
  int          irq_total = 0;
  int          stb_total = 0;

  video_out_fetch #(
    .P_WIDTH(16), .P_HEIGHT(2), .BURST_LEN(4), .IRQ_CYCLES(3)
  ) dut (
    .clk(clk), .nRST(nRST), .reg_ctr(reg_ctr), .reg_data(reg_data),
    .fifo_room(fifo_room), .fifo_data(fifo_data), .fifo_we(fifo_we),
    .interrupt(interrupt), .bus_err(bus_err),
    .p_wb_CYC_O(p_wb_CYC_O), .p_wb_STB_O(p_wb_STB_O), .p_wb_WE_O(p_wb_WE_O),
    .p_wb_SEL_O(p_wb_SEL_O), .p_wb_ADR_O(p_wb_ADR_O), .p_wb_DAT_I(p_wb_DAT_I),
    .p_wb_ACK_I(p_wb_ACK_I), .p_wb_ERR_I(p_wb_ERR_I)
  );

  always #5 clk = ~clk;

  // Slave: ACK on every strobe; an armed error raises ERR together with ACK once.
  assign p_wb_ERR_I = p_wb_CYC_O & p_wb_STB_O & (err_req != err_ack) & (p_wb_ADR_O == err_addr);
  assign p_wb_ACK_I = p_wb_CYC_O & p_wb_STB_O;
  assign p_wb_DAT_I = p_wb_ADR_O;

  always @(posedge clk) if (p_wb_ERR_I) err_ack <= err_ack + 1;

  always @(negedge clk) begin
    if (nRST === 1'b1) begin
      if (fifo_we) wr_q.push_back(fifo_data);
      if (p_wb_STB_O && p_wb_ACK_I && !p_wb_ERR_I) adr_q.push_back(p_wb_ADR_O);
      if (interrupt) irq_total = irq_total + 1;
      if (p_wb_STB_O) stb_total = stb_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_addr(input logic [31:0] a);
    @(negedge clk);
    reg_data = a;
    reg_ctr  = 1'b1;
    @(negedge clk);
    reg_ctr  = 1'b0;
  endtask

  task automatic wait_stb(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (p_wb_STB_O) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_err(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (p_wb_ERR_I) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_cyc_low(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!p_wb_CYC_O) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_writes(input string tag, input int base_idx, input int n);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (wr_q.size() - base_idx >= n) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Returns at the first negedge after the interrupt pulse has ended.
  task automatic wait_irq_done(input string tag);
    bit seen = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (interrupt) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic idle_check(input string tag);
    int c = 0;
    repeat (10) begin
      @(negedge clk);
      if (p_wb_CYC_O) c++;
    end
    chk(tag, 32'(c), 32'd0);
  endtask

  // Bring the block back to IDLE between frames.
  task automatic settle(input string tag);
`ifdef VIDEO_OUT_FETCH_AUTORELOAD_EN
    nRST = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    idle_check(tag);
`else
    idle_check(tag);
`endif
  endtask

  task automatic check_seq(input string tag, input int base_idx, input int n, input logic [31:0] a0,
                           input bit use_wr);
    chk({tag, "_count"}, 32'((use_wr ? wr_q.size() : adr_q.size()) - base_idx), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (base_idx + i < (use_wr ? wr_q.size() : adr_q.size()))
        chk($sformatf("%s_%0d", tag, i), use_wr ? wr_q[base_idx + i] : adr_q[base_idx + i],
            a0 + 32'(4 * i));
    end
  endtask

  initial begin
    int wb, ab, ib, s, c;
    nRST = 1'b0; reg_ctr = 1'b0; reg_data = 32'h0; fifo_room = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cyc", 32'(p_wb_CYC_O), 32'd0);
    chk("rst_stb", 32'(p_wb_STB_O), 32'd0);
    chk("rst_we", 32'(p_wb_WE_O), 32'd0);
    chk("rst_sel", 32'(p_wb_SEL_O), 32'hF);
    chk("rst_adr", p_wb_ADR_O, 32'h0);
    chk("rst_fifo_we", 32'(fifo_we), 32'd0);
    chk("rst_irq", 32'(interrupt), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    nRST = 1'b1;
    fifo_room = 1'b1;
    s = stb_total;
    repeat (10) @(negedge clk);
    chk("no_stb_without_edge", 32'(stb_total - s), 32'd0);

    // Frame A: base 0x1003, FIFO room withheld between bursts
    wb = wr_q.size(); ab = adr_q.size(); ib = irq_total;
    pulse_addr(32'h0000_1003);
    wait_stb("a_first_stb");
    chk("a_first_adr", p_wb_ADR_O, 32'h0000_1000);
    fifo_room = 1'b0;
    @(negedge clk);
    chk("a_we_latency", 32'(fifo_we), 32'd1);
    chk("a_we_data", fifo_data, 32'h0000_1000);
    wait_cyc_low("a_burst_end");
    c = 0;
    repeat (10) begin
      @(negedge clk);
      if (p_wb_CYC_O) c++;
    end
    chk("a_hold_no_cyc", 32'(c), 32'd0);
    fifo_room = 1'b1;
    @(negedge clk);
    chk("a_resume_stb", 32'(p_wb_STB_O), 32'd1);
    chk("a_resume_adr", p_wb_ADR_O, 32'h0000_1010);
    wait_irq_done("a_irq_done");
    check_seq("a_adr", ab, 8, 32'h0000_1000, 1'b0);
    check_seq("a_data", wb, 8, 32'h0000_1000, 1'b1);
    chk("a_irq_len", 32'(irq_total - ib), 32'd3);
    chk("a_bus_err", 32'(bus_err), 32'd0);
`ifdef VIDEO_OUT_FETCH_AUTORELOAD_EN
    chk("a_reload_gap", 32'(p_wb_STB_O), 32'd0);
    @(negedge clk);
    chk("a_reload_stb", 32'(p_wb_STB_O), 32'd1);
    chk("a_reload_adr", p_wb_ADR_O, 32'h0000_1000);
`endif
    settle("a_idle");

    // Frame B: ERR (with ACK) on the beat at 0x1008
    wb = wr_q.size(); ab = adr_q.size();
    err_addr = 32'h0000_1008;
    err_req  = err_req + 1;
    pulse_addr(32'h0000_1003);
    wait_err("b_err_seen");
    @(negedge clk);
    chk("b_gap_stb", 32'(p_wb_STB_O), 32'd0);
    chk("b_gap_cyc", 32'(p_wb_CYC_O), 32'd1);
    chk("b_bus_err_set", 32'(bus_err), 32'd1);
    @(negedge clk);
    chk("b_reissue_stb", 32'(p_wb_STB_O), 32'd1);
    chk("b_reissue_adr", p_wb_ADR_O, 32'h0000_1008);
    wait_irq_done("b_irq_done");
    check_seq("b_data", wb, 8, 32'h0000_1000, 1'b1);
    check_seq("b_adr", ab, 8, 32'h0000_1000, 1'b0);
    chk("b_bus_err_sticky", 32'(bus_err), 32'd1);
    settle("b_idle");

    // Frame C: new base 0x2000 arrives mid-frame
    wb = wr_q.size(); ab = adr_q.size();
    pulse_addr(32'h0000_1003);
    chk("c_bus_err_clr", 32'(bus_err), 32'd0);
    wait_writes("c_mid_frame", wb, 3);
    pulse_addr(32'h0000_2000);
    wait_irq_done("c_irq1_done");
    check_seq("c_adr1", ab, 8, 32'h0000_1000, 1'b0);
    chk("c_gap_stb", 32'(p_wb_STB_O), 32'd0);
    wb = wr_q.size();
    @(negedge clk);
    chk("c_next_stb", 32'(p_wb_STB_O), 32'd1);
    chk("c_next_adr", p_wb_ADR_O, 32'h0000_2000);
    wait_irq_done("c_irq2_done");
    check_seq("c_data2", wb, 8, 32'h0000_2000, 1'b1);
    settle("c_idle");

    // Async reset mid-burst discards the frame and the pending address
    pulse_addr(32'h0000_3000);
    wait_stb("r_first_stb");
    pulse_addr(32'h0000_4000);
    wait_stb("r_stb");
    @(posedge clk);
    #1 nRST = 1'b0;
    #1;
    chk("r_cyc", 32'(p_wb_CYC_O), 32'd0);
    chk("r_stb_low", 32'(p_wb_STB_O), 32'd0);
    chk("r_adr", p_wb_ADR_O, 32'h0);
    chk("r_sel", 32'(p_wb_SEL_O), 32'hF);
    chk("r_fifo_we", 32'(fifo_we), 32'd0);
    chk("r_fifo_data", fifo_data, 32'h0);
    chk("r_irq", 32'(interrupt), 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    s = stb_total;
    repeat (20) @(negedge clk);
    chk("r_no_restart", 32'(stb_total - s), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
